rf_wport_arbiter: RTL and testbench

//  Shares the single register-file write port between the pipeline WB stage and the

---
 rtl/rf_wport_if.sv | 37 +++
 rtl/rf_wport_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_if.sv
// Bundle of the register-file write-port arbiter signals: WB and LU requests, issue
// tracking, hazard queries and the single RF write port.
interface rf_wport_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              wb_write;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic [REG_W-1:0]  lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic              iss_valid;
    logic [REG_W-1:0]  iss_rd;
    logic [REG_W-1:0]  q1;
    logic [REG_W-1:0]  q2;
    logic              busy1;
    logic              busy2;
    logic              rf_write;
    logic [REG_W-1:0]  rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              stall_req;
    logic              waw_err;

    modport master (
        output wb_write, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
               iss_valid, iss_rd, q1, q2,
        input  lu_ready, busy1, busy2, rf_write, rf_rd, rf_data, stall_req, waw_err
    );

    modport slave (
        input  wb_write, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
               iss_valid, iss_rd, q1, q2,
        output lu_ready, busy1, busy2, rf_write, rf_rd, rf_data, stall_req, waw_err
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB (always wins) and a FIFO of long-latency results,
// tracks pending LU destinations for the hazard unit and requests a bubble on starvation.
module rf_wport_arbiter #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int NREG     = 32,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic        clk,
    input logic        rst,
    rf_wport_if.slave  bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [REG_W-1:0]  fifo_rd   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waw_q;

    logic empty;
    logic full;
    logic lu_xfer;
    logic push;
    logic drain;
    logic waw_hit;
    logic [REG_W-1:0] head_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head_rd = fifo_rd[rd_ptr];

    // Results for r0 complete the handshake but never occupy a FIFO slot.
    assign lu_xfer = bus.lu_valid && bus.lu_ready;
    assign push    = lu_xfer && (bus.lu_rd != '0);
    assign drain   = !rst && !bus.wb_write && !empty;

    // r0 is excluded from the "LU result without a pending bit" check: it is never tracked.
    assign waw_hit = (bus.iss_valid && pend[bus.iss_rd])
                   || (bus.wb_write && pend[bus.wb_rd])
                   || (push && !pend[bus.lu_rd]);

    assign bus.lu_ready  = !rst && !full;
    assign bus.busy1     = !rst && (bus.q1 != '0) && pend[bus.q1];
    assign bus.busy2     = !rst && (bus.q2 != '0) && pend[bus.q2];
    assign bus.stall_req = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign bus.waw_err   = waw_q;

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        bus.rf_write = 1'b0;
        bus.rf_rd    = '0;
        bus.rf_data  = '0;
        if (!rst) begin
            if (bus.wb_write) begin
                if (bus.wb_rd != '0) begin
                    bus.rf_write = 1'b1;
                    bus.rf_rd    = bus.wb_rd;
                    bus.rf_data  = bus.wb_data;
                end
            end else if (!empty) begin
                bus.rf_write = 1'b1;
                bus.rf_rd    = head_rd;
                bus.rf_data  = fifo_data[rd_ptr];
            end
        end
    end

    // Clear on drain first so a same-cycle issue to that index wins.
    always_comb begin
        pend_next = pend;
        if (drain) pend_next[head_rd] = 1'b0;
        if (bus.iss_valid && (bus.iss_rd != '0)) pend_next[bus.iss_rd] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend     <= '0;
            wait_cnt <= '0;
            waw_q    <= 1'b0;
        end else begin
            if (push)  wr_ptr <= ptr_inc(wr_ptr);
            if (drain) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            pend <= pend_next;
            if (!empty && bus.wb_write) begin
                if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (waw_hit) waw_q <= 1'b1;
        end
    end

    // NOTE: the payload storage has no reset; occupancy is governed solely by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.lu_rd;
            fifo_data[wr_ptr] <= bus.lu_data;
        end
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized self-checking bench for rf_wport_arbiter against a queue-based reference
// model, preceded by directed scenarios with hand-computed expectations.
module tb_rf_wport_arbiter;
    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int NREG     = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wport_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    rf_wport_arbiter #(
        .DATA_W(DATA_W), .REG_W(REG_W), .NREG(NREG), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: result queue, pending set, wait count, sticky error.
    logic [REG_W-1:0]  q_rd[$];
    logic [DATA_W-1:0] q_data[$];
    bit                pend[NREG];
    int                wcnt;
    bit                waw;

    logic              e_lu_ready, e_rf_write, e_busy1, e_busy2, e_stall, e_waw;
    logic [REG_W-1:0]  e_rf_rd;
    logic [DATA_W-1:0] e_rf_data;

    logic [REG_W-1:0]  inflight[$];
    bit                stall_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.wb_write  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.q1        = '0;
        bus.q2        = '0;
    endtask

    // Mid-cycle: derive expected outputs from the model and compare.
    task automatic settle();
        #4;
        e_lu_ready = !rst && (q_rd.size() < DEPTH);
        e_rf_write = 1'b0;
        e_rf_rd    = '0;
        e_rf_data  = '0;
        if (!rst) begin
            if (bus.wb_write) begin
                if (bus.wb_rd != 0) begin
                    e_rf_write = 1'b1;
                    e_rf_rd    = bus.wb_rd;
                    e_rf_data  = bus.wb_data;
                end
            end else if (q_rd.size() > 0) begin
                e_rf_write = 1'b1;
                e_rf_rd    = q_rd[0];
                e_rf_data  = q_data[0];
            end
        end
        e_busy1 = !rst && (bus.q1 != 0) && pend[bus.q1];
        e_busy2 = !rst && (bus.q2 != 0) && pend[bus.q2];
        e_stall = (wcnt == MAX_WAIT);
        e_waw   = waw;
        check("lu_ready",  bus.lu_ready,  e_lu_ready);
        check("rf_write",  bus.rf_write,  e_rf_write);
        check("rf_rd",     bus.rf_rd,     e_rf_rd);
        check("rf_data",   bus.rf_data,   e_rf_data);
        check("busy1",     bus.busy1,     e_busy1);
        check("busy2",     bus.busy2,     e_busy2);
        check("stall_req", bus.stall_req, e_stall);
        check("waw_err",   bus.waw_err,   e_waw);
    endtask

    // Clock edge: advance the model with the inputs that were present at the edge.
    task automatic edge_update();
        int sz;
        bit xfer;
        @(posedge clk);
        if (rst) begin
            q_rd.delete();
            q_data.delete();
            pend = '{default: 1'b0};
            wcnt = 0;
            waw  = 1'b0;
        end else begin
            sz   = q_rd.size();
            xfer = bus.lu_valid && e_lu_ready;
            if (bus.iss_valid && pend[bus.iss_rd]) waw = 1'b1;
            if (bus.wb_write && pend[bus.wb_rd]) waw = 1'b1;
            if (xfer && bus.lu_rd != 0 && !pend[bus.lu_rd]) waw = 1'b1;
            if (sz > 0 && bus.wb_write) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
            else wcnt = 0;
            if (!bus.wb_write && sz > 0) begin
                pend[q_rd[0]] = 1'b0;
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (bus.iss_valid && bus.iss_rd != 0) pend[bus.iss_rd] = 1'b1;
            if (xfer && bus.lu_rd != 0) begin
                q_rd.push_back(bus.lu_rd);
                q_data.push_back(bus.lu_data);
            end
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        edge_update();
    endtask

    task automatic issue(input logic [REG_W-1:0] r);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = r;
        cycle();
    endtask

    function automatic bit is_inflight(input logic [REG_W-1:0] r);
        foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        idle();
        rst  = 1'b1;
        pend = '{default: 1'b0};
        wcnt = 0;
        waw  = 1'b0;
        @(posedge clk);
        #1;
        settle();
        check("reset lu_ready", bus.lu_ready, 1'b0);
        check("reset rf_write", bus.rf_write, 1'b0);
        edge_update();
        rst = 1'b0;
        settle();
        check("post-reset stall_req", bus.stall_req, 1'b0);
        check("post-reset waw_err", bus.waw_err, 1'b0);
        edge_update();

        // WB wins the port with zero latency.
        idle();
        bus.wb_write = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hAA;
        settle();
        check("t1 rf_write", bus.rf_write, 1'b1);
        check("t1 rf_rd", bus.rf_rd, 5'd5);
        check("t1 rf_data", bus.rf_data, 32'hAA);
        edge_update();

        // Single LU result drains on the next idle WB cycle.
        issue(5'd7);
        idle();
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h1234; bus.q1 = 5'd7;
        settle();
        check("t2 lu_ready", bus.lu_ready, 1'b1);
        check("t2 busy1 before", bus.busy1, 1'b1);
        edge_update();
        idle();
        bus.q1 = 5'd7;
        settle();
        check("t2 rf_write", bus.rf_write, 1'b1);
        check("t2 rf_rd", bus.rf_rd, 5'd7);
        check("t2 rf_data", bus.rf_data, 32'h1234);
        check("t2 busy1 at drain", bus.busy1, 1'b1);
        edge_update();
        idle();
        bus.q1 = 5'd7;
        settle();
        check("t2 busy1 after", bus.busy1, 1'b0);
        edge_update();

        // Fill the FIFO behind WB traffic, hold a third result, then drain in order.
        issue(5'd8);
        issue(5'd9);
        issue(5'd10);
        idle();
        bus.wb_write = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h11;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd8; bus.lu_data = 32'h800;
        cycle();
        bus.lu_rd = 5'd9; bus.lu_data = 32'h900;
        cycle();
        bus.lu_rd = 5'd10; bus.lu_data = 32'hA00;
        settle();
        check("t3 full lu_ready", bus.lu_ready, 1'b0);
        edge_update();
        bus.wb_write = 1'b0;
        settle();
        check("t3 first rd", bus.rf_rd, 5'd8);
        check("t3 first data", bus.rf_data, 32'h800);
        edge_update();
        settle();
        check("t3 second rd", bus.rf_rd, 5'd9);
        check("t3 lu_ready back", bus.lu_ready, 1'b1);
        edge_update();
        idle();
        settle();
        check("t3 third rd", bus.rf_rd, 5'd10);
        check("t3 third data", bus.rf_data, 32'hA00);
        edge_update();

        // Starvation: four blocked cycles raise stall_req, one drain drops it.
        issue(5'd11);
        idle();
        bus.wb_write = 1'b1; bus.wb_rd = 5'd2;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd11; bus.lu_data = 32'hB0B;
        cycle();
        bus.lu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t4 stall low", bus.stall_req, 1'b0);
            edge_update();
        end
        bus.wb_write = 1'b0;
        settle();
        check("t4 stall high", bus.stall_req, 1'b1);
        check("t4 drain rd", bus.rf_rd, 5'd11);
        edge_update();
        settle();
        check("t4 stall cleared", bus.stall_req, 1'b0);
        edge_update();

        // Protocol errors and r0 handling.
        issue(5'd3);
        issue(5'd3);
        idle();
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'h55;
        settle();
        check("t5 waw_err", bus.waw_err, 1'b1);
        check("t5 r0 lu_ready", bus.lu_ready, 1'b1);
        edge_update();
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        settle();
        check("t5 r0 no write", bus.rf_write, 1'b0);
        edge_update();
        idle();
        settle();
        check("t5 r0 busy", bus.busy1, 1'b0);
        edge_update();

        // Reset with a full FIFO and pending bits.
        issue(5'd12);
        issue(5'd13);
        idle();
        bus.wb_write = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h44;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd12; bus.lu_data = 32'hC00;
        cycle();
        bus.lu_rd = 5'd3; bus.lu_data = 32'h300;
        cycle();
        idle();
        rst = 1'b1;
        bus.q1 = 5'd13; bus.q2 = 5'd12;
        settle();
        check("t6 rst rf_write", bus.rf_write, 1'b0);
        check("t6 rst lu_ready", bus.lu_ready, 1'b0);
        check("t6 rst busy1", bus.busy1, 1'b0);
        edge_update();
        rst = 1'b0;
        settle();
        check("t6 empty rf_write", bus.rf_write, 1'b0);
        check("t6 busy1 cleared", bus.busy1, 1'b0);
        check("t6 waw cleared", bus.waw_err, 1'b0);
        edge_update();

        // Randomized traffic following the issue/return protocol.
        stall_seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic [REG_W-1:0] r;
            idle();
            rst = ($urandom_range(0, 199) == 0);
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.lu_valid = 1'b1;
                bus.lu_rd    = inflight[0];
                bus.lu_data  = $urandom;
            end
            if ($urandom_range(0, 9) < 3) begin
                r = REG_W'($urandom_range(1, NREG - 1));
                if (!pend[r] && !is_inflight(r)) begin
                    bus.iss_valid = 1'b1;
                    bus.iss_rd    = r;
                end
            end
            if (!stall_seen && $urandom_range(0, 9) < 6) begin
                bus.wb_write = 1'b1;
                r            = REG_W'($urandom_range(0, NREG - 1));
                bus.wb_rd    = (pend[r] || is_inflight(r)) ? '0 : r;
                bus.wb_data  = $urandom;
            end
            bus.q1 = REG_W'($urandom_range(0, NREG - 1));
            bus.q2 = REG_W'($urandom_range(0, NREG - 1));
            cycle();
            stall_seen = e_stall;
            if (rst) begin
                inflight.delete();
            end else begin
                if (bus.lu_valid && e_lu_ready) void'(inflight.pop_front());
                if (bus.iss_valid) inflight.push_back(bus.iss_rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
